// File: rtl/fp_accum_rne.sv
// fp_accum_rne: streaming sign/exp/mant accumulator with RNE rounding, saturation and per-group results
module fp_accum_rne #(
  parameter int MANT_W = 23,
  parameter int EXP_W = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic              in_sign_i,
  input  logic [EXP_W-1:0]  in_exp_i,
  input  logic [MANT_W-1:0] in_mant_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_sign_o,
  output logic [EXP_W-1:0]  out_exp_o,
  output logic [MANT_W-1:0] out_mant_o,
  output logic [CNT_W-1:0]  out_cnt_o,
  output logic              out_ovf_o
);
  localparam int W = MANT_W + 4;
  localparam int SW = MANT_W + 3;
  localparam int EXP_TOP = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EXP_SAT = {{(EXP_W-1){1'b1}}, 1'b0};
  logic acc_full, acc_sign, ovf, accept, a_big, b_sign, s_sign;
  logic [EXP_W-1:0] acc_exp, b_exp, s_exp, r_exp, res_exp;
  logic [MANT_W-1:0] acc_mant, b_mant, s_mant, r_mant, res_mant;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0] b_ee, s_ee, diff, e, lz, sh, en, fe;
  logic [SW-1:0] ss, al;
  logic st, up, sat, zero, r_sign, res_sign, res_ovf;
  logic [W:0] sum;
  logic [W-1:0] n, nn;
  logic [MANT_W+1:0] m;
  assign in_ready_o = ~clear_i & ~(out_valid_o & ~out_ready_i);
  assign accept = in_valid_i & in_ready_o;
  assign a_big = {acc_exp, acc_mant} >= {in_exp_i, in_mant_i};
  assign b_sign = a_big ? acc_sign : in_sign_i;
  assign s_sign = a_big ? in_sign_i : acc_sign;
  assign b_exp = a_big ? acc_exp : in_exp_i;
  assign s_exp = a_big ? in_exp_i : acc_exp;
  assign b_mant = a_big ? acc_mant : in_mant_i;
  assign s_mant = a_big ? in_mant_i : acc_mant;
  assign b_ee = (b_exp == '0) ? 32'd1 : 32'(b_exp);
  assign s_ee = (s_exp == '0) ? 32'd1 : 32'(s_exp);
  assign diff = b_ee - s_ee;
  assign ss = {|s_exp, s_mant, 2'b00};
  assign al = (diff >= SW) ? '0 : ss >> diff;
  assign st = (diff >= SW) ? |ss : |(ss & ~({SW{1'b1}} << diff));
  assign sum = (b_sign == s_sign) ? {1'b0, |b_exp, b_mant, 3'b000} + {1'b0, al, st}
                                  : {1'b0, |b_exp, b_mant, 3'b000} - {1'b0, al, st};
  assign n = sum[W] ? {sum[W:2], |sum[1:0]} : sum[W-1:0];
  assign e = b_ee + 32'(sum[W]);
  always_comb begin
    lz = 32'(W);
    for (int i = 0; i < W; i++) lz = n[i] ? 32'(W - 1 - i) : lz;
  end
  assign sh = (lz > e - 1) ? e - 1 : lz;
  assign nn = n << sh;
  assign en = e - sh;
  assign up = nn[2] & (nn[1] | nn[0] | nn[3]);
  assign m = {1'b0, nn[W-1:3]} + {{(MANT_W+1){1'b0}}, up};
  assign fe = m[MANT_W+1] ? en + 1 : (m[MANT_W] ? en : 32'd0);
  assign sat = fe >= EXP_TOP;
  assign zero = m == '0;
  assign r_sign = b_sign & ~zero;
  assign r_exp = sat ? EXP_SAT : fe[EXP_W-1:0];
  assign r_mant = sat ? '1 : m[MANT_W-1:0];
  assign res_sign = acc_full ? r_sign : in_sign_i;
  assign res_exp = acc_full ? r_exp : in_exp_i;
  assign res_mant = acc_full ? r_mant : in_mant_i;
  assign res_ovf = acc_full & sat;
  assign cnt_nx = (cnt == '1) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_full <= 1'b0;
      acc_sign <= 1'b0;
      acc_exp <= '0;
      acc_mant <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_valid_o <= 1'b0;
      out_sign_o <= 1'b0;
      out_exp_o <= '0;
      out_mant_o <= '0;
      out_cnt_o <= '0;
      out_ovf_o <= 1'b0;
    end else begin
      if (clear_i) begin
        acc_full <= 1'b0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        acc_full <= ~in_last_i;
        acc_sign <= res_sign;
        acc_exp <= res_exp;
        acc_mant <= res_mant;
        cnt <= in_last_i ? '0 : cnt_nx;
        ovf <= ~in_last_i & (ovf | res_ovf);
      end
      if (accept & in_last_i) begin
        out_valid_o <= 1'b1;
        out_sign_o <= res_sign;
        out_exp_o <= res_exp;
        out_mant_o <= res_mant;
        out_cnt_o <= cnt_nx;
        out_ovf_o <= ovf | res_ovf;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_accum_rne.sv
// tb_fp_accum_rne: directed vector table, corner sequences and random stimulus against an exact-arithmetic model
module tb_fp_accum_rne;
  localparam int MW = 23;
  localparam int EW = 8;
  localparam int CW = 8;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, in_last = 1'b0, in_sign = 1'b0, out_ready = 1'b1;
  logic [EW-1:0] in_exp = '0;
  logic [MW-1:0] in_mant = '0;
  logic in_ready, out_valid, out_sign, out_ovf;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_mant;
  logic [CW-1:0] out_cnt;
  int checks = 0, fails = 0;
  bit m_full, m_ovf, m_ov, m_oovf;
  logic [31:0] m_acc, m_out;
  int m_cnt, m_ocnt;
  typedef struct {
    int n;
    logic [31:0] t [3];
    logic [31:0] res;
    int cnt;
    bit ovf;
  } vec_t;
  vec_t vt [11];

  always #5 clk = ~clk;

  fp_accum_rne #(.MANT_W(MW), .EXP_W(EW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_last_i(in_last), .in_sign_i(in_sign), .in_exp_i(in_exp), .in_mant_i(in_mant),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sign_o(out_sign), .out_exp_o(out_exp),
    .out_mant_o(out_mant), .out_cnt_o(out_cnt), .out_ovf_o(out_ovf)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [299:0] mag(logic [31:0] w);
    int ee = (w[30:23] == 8'd0) ? 1 : int'(w[30:23]);
    logic [299:0] v = {276'd0, |w[30:23], w[22:0]};
    return v << (ee - 1);
  endfunction

  function automatic logic [32:0] fadd(logic [31:0] a, logic [31:0] b);
    logic [299:0] ma, mb, mg, q, rem, half;
    int p, k;
    bit sg;
    ma = mag(a);
    mb = mag(b);
    if (a[31] == b[31]) begin mg = ma + mb; sg = a[31]; end
    else if (ma >= mb) begin mg = ma - mb; sg = a[31]; end
    else begin mg = mb - ma; sg = b[31]; end
    if (mg == '0) return 33'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mg[i]) p = i;
    if (p <= 23) return {1'b0, sg, (p == 23) ? 8'd1 : 8'd0, mg[22:0]};
    k = p - 23;
    q = mg >> k;
    rem = mg - (q << k);
    half = 300'd1 << (k - 1);
    if (rem > half || (rem == half && q[0])) q = q + 300'd1;
    if (q[24]) begin q = q >> 1; k++; end
    if (k + 1 >= 255) return {1'b1, sg, 8'hFE, 23'h7FFFFF};
    return {1'b0, sg, 8'(k + 1), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_term();
    int sel = $urandom_range(0, 9);
    logic [22:0] m = 23'($urandom);
    logic [7:0] e;
    if ($urandom_range(0, 3) == 0) m = m & 23'h7;
    e = (sel == 0) ? 8'd0 : (sel == 1) ? 8'($urandom_range(250, 254)) : 8'($urandom_range(118, 136));
    return {1'($urandom), e, m};
  endfunction

  task automatic set_term(logic [31:0] w);
    {in_sign, in_exp, in_mant} = w;
  endtask

  task automatic cycle();
    logic [32:0] r;
    logic [31:0] s;
    bit o, rdy;
    int c;
    #2;
    rdy = !clear && !(m_ov && !out_ready);
    if (!rst) chk("in_ready", 64'(in_ready), 64'(rdy));
    if (rst) begin
      m_full = 0; m_cnt = 0; m_ovf = 0; m_ov = 0; m_out = '0; m_ocnt = 0; m_oovf = 0;
    end else begin
      if (out_ready) m_ov = 0;
      if (clear) begin
        m_full = 0; m_cnt = 0; m_ovf = 0;
      end else if (in_valid && rdy) begin
        if (m_full) begin r = fadd(m_acc, {in_sign, in_exp, in_mant}); s = r[31:0]; o = r[32]; end
        else begin s = {in_sign, in_exp, in_mant}; o = 0; end
        c = (m_cnt == 255) ? 255 : m_cnt + 1;
        if (in_last) begin
          m_ov = 1; m_out = s; m_ocnt = c; m_oovf = m_ovf | o;
          m_full = 0; m_cnt = 0; m_ovf = 0;
        end else begin
          m_full = 1; m_acc = s; m_cnt = c; m_ovf = m_ovf | o;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_word", 64'({out_sign, out_exp, out_mant}), 64'(m_out));
    chk("out_cnt", 64'(out_cnt), 64'(m_ocnt));
    chk("out_ovf", 64'(out_ovf), 64'(m_oovf));
  endtask

  task automatic run_vec(vec_t v, int idx);
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1; in_last = (i == v.n - 1); out_ready = 1;
      set_term(v.t[i]);
      cycle();
    end
    in_valid = 0; in_last = 0;
    chk($sformatf("vec%0d_valid", idx), 64'(out_valid), 64'd1);
    chk($sformatf("vec%0d_res", idx), 64'({out_sign, out_exp, out_mant}), 64'(v.res));
    chk($sformatf("vec%0d_cnt", idx), 64'(out_cnt), 64'(v.cnt));
    chk($sformatf("vec%0d_ovf", idx), 64'(out_ovf), 64'(v.ovf));
    cycle();
  endtask

  initial begin
    vt[0]  = '{3, '{32'h3F800000, 32'h40000000, 32'h3F000000}, 32'h40600000, 3, 0};
    vt[1]  = '{2, '{32'h3F800000, 32'hBF800000, 32'h0}, 32'h00000000, 2, 0};
    vt[2]  = '{2, '{32'h3F800001, 32'h33800000, 32'h0}, 32'h3F800002, 2, 0};
    vt[3]  = '{2, '{32'h3F800000, 32'h33800000, 32'h0}, 32'h3F800000, 2, 0};
    vt[4]  = '{2, '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0}, 32'h7F7FFFFF, 2, 1};
    vt[5]  = '{1, '{32'h3F800000, 32'h0, 32'h0}, 32'h3F800000, 1, 0};
    vt[6]  = '{2, '{32'h00000001, 32'h007FFFFF, 32'h0}, 32'h00800000, 2, 0};
    vt[7]  = '{2, '{32'h3FC00000, 32'hBE800000, 32'h0}, 32'h3FA00000, 2, 0};
    vt[8]  = '{2, '{32'h3F800001, 32'hBF800000, 32'h0}, 32'h34000000, 2, 0};
    vt[9]  = '{1, '{32'hFF800000, 32'h0, 32'h0}, 32'hFF800000, 1, 0};
    vt[10] = '{3, '{32'h4B800000, 32'h3F800000, 32'h3F800000}, 32'h4B800000, 3, 0};
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 11; i++) run_vec(vt[i], i);
    in_valid = 1; in_last = 0; out_ready = 0; set_term(32'h3F800000); cycle();
    in_last = 1; set_term(32'h40000000); cycle();
    for (int i = 0; i < 5; i++) begin
      in_last = 0; set_term(32'h41000000); cycle();
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_hold", 64'({out_valid, out_sign, out_exp, out_mant}), 64'({1'b1, 32'h40400000}));
    end
    in_valid = 0; out_ready = 1;
    #2 chk("bp_release_ready", 64'(in_ready), 64'd1);
    cycle();
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    in_valid = 1; in_last = 0; set_term(32'h40400000); cycle();
    set_term(32'h40800000); cycle();
    clear = 1; in_last = 1; set_term(32'h41000000); cycle();
    chk("clear_no_output", 64'(out_valid), 64'd0);
    clear = 0; set_term(32'h3F800000); cycle();
    chk("clear_res", 64'({out_sign, out_exp, out_mant}), 64'h3F800000);
    chk("clear_cnt", 64'(out_cnt), 64'd1);
    in_last = 0; set_term(32'h40400000); cycle();
    rst = 1; in_valid = 0; cycle();
    rst = 0;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    in_valid = 1; in_last = 1; out_ready = 0; set_term(32'h3F800000); cycle();
    chk("rst_after_cnt", 64'(out_cnt), 64'd1);
    rst = 1; in_valid = 0; cycle();
    rst = 0;
    chk("rst_pending_valid", 64'(out_valid), 64'd0);
    out_ready = 1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1; in_last = (i == 299); set_term(32'h3F800000); cycle();
    end
    chk("cnt_sat", 64'(out_cnt), 64'd255);
    chk("cnt_sat_res", 64'({out_sign, out_exp, out_mant}), 64'h43960000);
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      clear = ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_last = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_term(rand_term());
      cycle();
    end
    rst = 0; clear = 0; in_valid = 0; in_last = 0; out_ready = 1;
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
